nlms_weight_update: RTL and testbench
=====================================

// Module: nlms_weight_update
// PURPOSE
//  - Weight-update engine for the 16-tap adaptive filter: consumes error e and tap samples, writes back the weights the filter reads.
//  - Per update: w[k] <= w[k] + ((e * x[k]) >>> MU_SHIFT), one tap per clock over 16 clocks.
//  - All 16 weights are committed to weight_out atomically, so the filter never sees a half-updated set.
// PARAMETERS
//  NTAP      16  number of taps (weights / samples)
//  XW        14  sample width, two's complement
//  EW        11  error width, two's complement
//  WW        32  weight width, two's complement
//  MU_SHIFT  8   step size mu = 2^-MU_SHIFT (arithmetic right shift)
// PORTS
//  clk         in   1          clock, all flops on posedge
//  rstn        in   1          asynchronous active-low reset
//  en          in   1          update enable; low aborts any update in flight
//  w_load      in   1          pulse: load w_init into working and output weights (IDLE only)
//  w_init      in   NTAP*WW    initial weights, tap k at [k*WW +: WW]
//  upd_start   in   1          pulse: start one update using err and x_in
//  err         in   EW         error sample, sampled on the upd_start edge
//  x_in        in   NTAP*XW    tap samples, tap k at [k*XW +: XW], sampled on the upd_start edge
//  upd_busy    out  1          high in CALC
//  upd_done    out  1          one-cycle pulse when weight_out takes the new set
//  weight_out  out  NTAP*WW    committed weights, tap k at [k*WW +: WW]
// BEHAVIOUR
//  - Reset: FSM=IDLE, tap counter=0, working and committed weights=0, upd_busy=0, upd_done=0.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//  - IDLE: on upd_start&en, snapshot err and all NTAP samples, set k=0, go to CALC.
//    - w_load&~upd_start: load w_init into working and committed weights. No done pulse.
//    - w_load&upd_start in the same cycle: upd_start wins; w_load is ignored.
//  - CALC: each cycle k updates working w[k]; k increments each cycle; after k=NTAP-1 go to DONE.
//    - Exactly NTAP cycles.
//    - upd_start and w_load are ignored in CALC and DONE.
//  - DONE: committed weights <= working weights, and upd_done=1 on the same edge; next state IDLE.
//  - Latency: upd_start sampled at edge 0 -> upd_done high and weight_out new after edge NTAP+1 (17).
//    - Back-to-back upd_start is accepted in the cycle after done.
//  - Abort: en=0 in CALC/DONE -> IDLE next edge, working <= committed (rollback), no upd_done.
//  - en=0 in IDLE: upd_start is ignored; w_load is still honoured.
//  - Arithmetic:
//    - prod = signed(err)*signed(x[k]), width EW+XW=25.
//    - delta = prod >>> MU_SHIFT, floor rounding; e.g. -1 >>> 8 = -1.
//    - delta is sign-extended to WW, then sum = w[k] + delta.
//  - Overflow without NLMS_WSAT_EN: sum wraps modulo 2^WW.
//  - Reset mid-operation: immediate return to reset values; no partial commit.
// CONFIGURATION
//  NLMS_WSAT_EN defined:
//    - sum is saturated to [-2^(WW-1), 2^(WW-1)-1], detected from the sign bits of w, delta and sum.
//  NLMS_WSAT_EN undefined:
//    - two's-complement wrap; no saturation logic is generated.
// STRUCTURE
//  - Shared package nlms_pkg:
//    - NTAP/XW/EW/WW defaults.
//    - state enum {IDLE, CALC, DONE}.
//    - typedefs for sample_t, err_t, weight_t.
//  - One sub-module nlms_tap_mac: combinational prod/shift/extend/add(/sat).
//    - Inputs: one weight, err, sample. Output: new weight.
//    - Instantiated once and time-shared over k.
//  - Top level holds the FSM, counter, snapshot regs and the working/committed weight banks.
// TESTING
//  1. Reset, then upd_start with err=16, all x=256, MU_SHIFT=8 -> upd_done at edge 17; every weight = 16; upd_busy high 16 cycles.
//  2. Follow-up upd_start with err=-16, same x -> all weights return to 0.
//  3. Rounding: err=-1, x[3]=1, other x=0 -> w[3]=0xFFFFFFFF, other weights 0; err=1, x=1 -> weights unchanged.
//  4. Abort: en dropped when k=5 -> no upd_done, weight_out unchanged, next update starts cleanly from committed values.
//  5. Overflow: w_load all 0x7FFFFFF0, err=1023, x=8191 (delta=32732):
//     - NLMS_WSAT_EN: 0x7FFFFFFF.
//     - Without it: 0x80007FCC.
//  6. Protocol: upd_start during CALC ignored; w_load during CALC ignored; rstn low at k=8 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/nlms_pkg.sv
// Shared definitions for the NLMS weight-update engine: default sizes,
// FSM state encoding and the scalar data types used by the datapath.
package nlms_pkg;

    localparam int NTAP     = 16;
    localparam int XW       = 14;
    localparam int EW       = 11;
    localparam int WW       = 32;
    localparam int MU_SHIFT = 8;
    localparam int KW       = $clog2(NTAP);

    typedef logic signed [XW-1:0] sample_t;
    typedef logic signed [EW-1:0] err_t;
    typedef logic signed [WW-1:0] weight_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nlms_tap_mac.sv
// Single-tap update datapath: new_w = w + ((err * x) >>> MU_SHIFT).
// The product is floor-shifted, sign-extended to the weight width and added.
// Build option NLMS_WSAT_EN: saturate the sum instead of wrapping.
module nlms_tap_mac
    import nlms_pkg::*;
(
    input  weight_t i_w,
    input  err_t    i_err,
    input  sample_t i_x,
    output weight_t o_w
);

    localparam int PW = EW + XW;

    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_delta;
    weight_t              w_delta_ext;
    weight_t              w_sum;

    // Product, floor shift (arithmetic), sign extension and raw add.
    always_comb begin
        w_prod      = i_err * i_x;
        w_delta     = w_prod >>> MU_SHIFT;
        w_delta_ext = {{(WW-PW){w_delta[PW-1]}}, w_delta};
        w_sum       = i_w + w_delta_ext;
    end

`ifdef NLMS_WSAT_EN
    logic w_ovf;

    // Overflow only when both addends share a sign the sum does not; clamp toward that sign.
    always_comb begin
        w_ovf = (i_w[WW-1] == w_delta_ext[WW-1]) && (w_sum[WW-1] != i_w[WW-1]);
        if (w_ovf) begin
            if (i_w[WW-1]) begin
                o_w = {1'b1, {(WW-1){1'b0}}};
            end else begin
                o_w = {1'b0, {(WW-1){1'b1}}};
            end
        end else begin
            o_w = w_sum;
        end
    end
`else
    // Plain two's-complement wrap.
    always_comb begin
        o_w = w_sum;
    end
`endif

endmodule

// File: rtl/nlms_weight_update.sv
// NLMS weight-update engine: one tap per clock through a shared MAC into a
// working bank, then an atomic copy into the committed bank the filter reads.
// Build option NLMS_WSAT_EN selects saturating weight arithmetic.
module nlms_weight_update
    import nlms_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 w_load,
    input  logic [NTAP*WW-1:0]   w_init,
    input  logic                 upd_start,
    input  logic [EW-1:0]        err,
    input  logic [NTAP*XW-1:0]   x_in,
    output logic                 upd_busy,
    output logic                 upd_done,
    output logic [NTAP*WW-1:0]   weight_out
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [KW-1:0] r_k;
    err_t          r_err;
    sample_t       r_x      [NTAP];
    weight_t       r_work   [NTAP];
    weight_t       r_commit [NTAP];
    logic          r_busy;
    logic          r_done;

    weight_t       w_cur_w;
    sample_t       w_cur_x;
    weight_t       w_new_w;
    logic          w_accept;

    // Start is only taken from IDLE with the engine enabled.
    always_comb begin
        w_accept = (r_state == IDLE) && en && upd_start;
    end

    // Next-state logic; dropping en anywhere past IDLE aborts back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                end else if (r_k == KW'(NTAP-1)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register plus registered busy/done flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == CALC);
            r_done  <= (r_state == DONE) && en;
        end
    end

    // Tap counter: cleared on start or abort, stepped once per CALC cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_k <= '0;
        end else if (w_accept) begin
            r_k <= '0;
        end else if ((r_state == CALC) && en) begin
            r_k <= r_k + KW'(1);
        end else if (r_state != CALC) begin
            r_k <= '0;
        end else begin
            r_k <= '0;
        end
    end

    // Snapshot of error and samples taken on the accepted start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= '0;
            for (int i = 0; i < NTAP; i++) begin
                r_x[i] <= '0;
            end
        end else if (w_accept) begin
            r_err <= err;
            for (int i = 0; i < NTAP; i++) begin
                r_x[i] <= x_in[i*XW +: XW];
            end
        end
    end

    // Current tap operands for the shared MAC.
    always_comb begin
        w_cur_w = r_work[r_k];
        w_cur_x = r_x[r_k];
    end

    nlms_tap_mac u_mac (
        .i_w   (w_cur_w),
        .i_err (r_err),
        .i_x   (w_cur_x),
        .o_w   (w_new_w)
    );

    // Working bank: load, per-tap update, or rollback to committed on abort.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NTAP; i++) begin
                r_work[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_accept && w_load) begin
                        for (int i = 0; i < NTAP; i++) begin
                            r_work[i] <= w_init[i*WW +: WW];
                        end
                    end
                end
                CALC: begin
                    if (en) begin
                        r_work[r_k] <= w_new_w;
                    end else begin
                        for (int i = 0; i < NTAP; i++) begin
                            r_work[i] <= r_commit[i];
                        end
                    end
                end
                DONE: begin
                    if (!en) begin
                        for (int i = 0; i < NTAP; i++) begin
                            r_work[i] <= r_commit[i];
                        end
                    end
                end
                default: begin
                    for (int i = 0; i < NTAP; i++) begin
                        r_work[i] <= r_commit[i];
                    end
                end
            endcase
        end
    end

    // Committed bank: changes only on load in IDLE or a completed update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NTAP; i++) begin
                r_commit[i] <= '0;
            end
        end else if ((r_state == IDLE) && !w_accept && w_load) begin
            for (int i = 0; i < NTAP; i++) begin
                r_commit[i] <= w_init[i*WW +: WW];
            end
        end else if ((r_state == DONE) && en) begin
            for (int i = 0; i < NTAP; i++) begin
                r_commit[i] <= r_work[i];
            end
        end
    end

    // Flatten committed bank and drive the flag outputs from their registers.
    always_comb begin
        weight_out = '0;
        for (int i = 0; i < NTAP; i++) begin
            weight_out[i*WW +: WW] = r_commit[i];
        end
        upd_busy = r_busy;
        upd_done = r_done;
    end

endmodule

// File: tb/tb_nlms_weight_update.sv
// Directed self-checking bench for nlms_weight_update.
module tb_nlms_weight_update;
    import nlms_pkg::*;

    logic                clk;
    logic                rstn;
    logic                en;
    logic                w_load;
    logic [NTAP*WW-1:0]  w_init;
    logic                upd_start;
    logic [EW-1:0]       err;
    logic [NTAP*XW-1:0]  x_in;
    logic                upd_busy;
    logic                upd_done;
    logic [NTAP*WW-1:0]  weight_out;

    int n_checks = 0;
    int n_errors = 0;

    nlms_weight_update dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .w_load     (w_load),
        .w_init     (w_init),
        .upd_start  (upd_start),
        .err        (err),
        .x_in       (x_in),
        .upd_busy   (upd_busy),
        .upd_done   (upd_done),
        .weight_out (weight_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NTAP*WW-1:0] rep_w(input logic [WW-1:0] v);
        logic [NTAP*WW-1:0] r;
        for (int i = 0; i < NTAP; i++) r[i*WW +: WW] = v;
        return r;
    endfunction

    function automatic logic [NTAP*XW-1:0] rep_x(input logic [XW-1:0] v);
        logic [NTAP*XW-1:0] r;
        for (int i = 0; i < NTAP; i++) r[i*XW +: XW] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start; returns edge index of upd_done (-1 on timeout) and busy cycles seen.
    task automatic run_update(input logic [EW-1:0] e, input logic [NTAP*XW-1:0] x,
                              output int done_edge, output int busy_cnt);
        done_edge = -1;
        busy_cnt  = 0;
        err = e;
        x_in = x;
        upd_start = 1'b1;
        tick();
        upd_start = 1'b0;
        if (upd_busy) busy_cnt++;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (upd_busy) busy_cnt++;
            if (upd_done) begin
                done_edge = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b1; w_load = 1'b0; w_init = '0;
        upd_start = 1'b0; err = '0; x_in = '0;
        repeat (3) tick();
        n_checks++;
        if (weight_out !== '0) begin n_errors++; $display("FAIL reset_weights: got %h expected 0", weight_out); end
        n_checks++;
        if (upd_busy !== 1'b0 || upd_done !== 1'b0) begin
            n_errors++; $display("FAIL reset_flags: busy=%b done=%b expected 0 0", upd_busy, upd_done);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int de, bc;
        run_update(11'sd16, rep_x(14'd256), de, bc);
        n_checks++;
        if (de !== 17) begin n_errors++; $display("FAIL basic_latency: got %0d expected 17", de); end
        n_checks++;
        if (bc !== 16) begin n_errors++; $display("FAIL basic_busy_cycles: got %0d expected 16", bc); end
        n_checks++;
        if (weight_out !== rep_w(32'd16)) begin n_errors++; $display("FAIL basic_weights: got %h expected all 16", weight_out); end
    endtask

    task automatic test_back_to_back();
        int de, bc;
        // Issued in the cycle upd_done is high.
        run_update(-11'sd16, rep_x(14'd256), de, bc);
        n_checks++;
        if (de !== 17) begin n_errors++; $display("FAIL b2b_latency: got %0d expected 17", de); end
        n_checks++;
        if (weight_out !== '0) begin n_errors++; $display("FAIL b2b_weights: got %h expected 0", weight_out); end
        tick();
        n_checks++;
        if (upd_done !== 1'b0) begin n_errors++; $display("FAIL done_one_cycle: got %b expected 0", upd_done); end
    endtask

    task automatic test_rounding();
        int de, bc;
        logic [NTAP*XW-1:0] x;
        logic [NTAP*WW-1:0] exp_w;
        x = '0;
        x[3*XW +: XW] = 14'd1;
        exp_w = '0;
        exp_w[3*WW +: WW] = 32'hFFFF_FFFF;
        run_update(-11'sd1, x, de, bc);
        n_checks++;
        if (weight_out !== exp_w) begin n_errors++; $display("FAIL round_neg: got %h expected %h", weight_out, exp_w); end
        tick();
        run_update(11'sd1, rep_x(14'd1), de, bc);
        n_checks++;
        if (weight_out !== exp_w) begin n_errors++; $display("FAIL round_pos: got %h expected %h", weight_out, exp_w); end
        tick();
    endtask

    task automatic test_abort();
        int de, bc, dones;
        logic [NTAP*WW-1:0] before_w, exp_w;
        before_w = '0;
        before_w[3*WW +: WW] = 32'hFFFF_FFFF;
        err = 11'sd16; x_in = rep_x(14'd256);
        upd_start = 1'b1;
        tick();
        upd_start = 1'b0;
        repeat (5) tick();   // k = 5 now
        en = 1'b0;
        tick();
        n_checks++;
        if (upd_busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b expected 0", upd_busy); end
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (upd_done) dones++;
            tick();
        end
        n_checks++;
        if (dones !== 0) begin n_errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
        n_checks++;
        if (weight_out !== before_w) begin n_errors++; $display("FAIL abort_weights: got %h expected %h", weight_out, before_w); end
        en = 1'b1;
        run_update(11'sd16, rep_x(14'd256), de, bc);
        exp_w = rep_w(32'd16);
        exp_w[3*WW +: WW] = 32'd15;
        n_checks++;
        if (weight_out !== exp_w) begin n_errors++; $display("FAIL abort_restart: got %h expected %h", weight_out, exp_w); end
        tick();
    endtask

    task automatic test_overflow();
        int de, bc;
        logic [WW-1:0] exp_v;
        w_init = rep_w(32'h7FFF_FFF0);
        w_load = 1'b1;
        tick();
        w_load = 1'b0;
        n_checks++;
        if (weight_out !== rep_w(32'h7FFF_FFF0) || upd_done !== 1'b0) begin
            n_errors++; $display("FAIL load: got %h done=%b expected all 7ffffff0 done=0", weight_out, upd_done);
        end
        run_update(11'sd1023, rep_x(14'd8191), de, bc);
`ifdef NLMS_WSAT_EN
        exp_v = 32'h7FFF_FFFF;
`else
        exp_v = 32'h8000_7FCC;
`endif
        n_checks++;
        if (weight_out !== rep_w(exp_v)) begin n_errors++; $display("FAIL overflow: got %h expected all %h", weight_out, exp_v); end
        tick();
    endtask

    task automatic test_protocol();
        int de, bc, dones;
        w_init = '0; w_load = 1'b1;
        tick();
        w_load = 1'b0;
        // en low in IDLE: start ignored.
        en = 1'b0; err = 11'sd16; x_in = rep_x(14'd256); upd_start = 1'b1;
        repeat (3) tick();
        upd_start = 1'b0;
        n_checks++;
        if (upd_busy !== 1'b0 || weight_out !== '0) begin
            n_errors++; $display("FAIL en_low_start: busy=%b w=%h expected 0 0", upd_busy, weight_out);
        end
        en = 1'b1;
        // Start with upd_start/w_load re-pulsed mid-CALC.
        upd_start = 1'b1;
        tick();
        upd_start = 1'b0;
        repeat (2) tick();
        upd_start = 1'b1; w_load = 1'b1; w_init = rep_w(32'd5); err = -11'sd16;
        tick();
        upd_start = 1'b0; w_load = 1'b0;
        de = -1;
        for (int n = 4; n <= 40; n++) begin
            tick();
            if (upd_done) begin de = n; break; end
        end
        n_checks++;
        if (de !== 17) begin n_errors++; $display("FAIL calc_ignore_latency: got %0d expected 17", de); end
        n_checks++;
        if (weight_out !== rep_w(32'd16)) begin n_errors++; $display("FAIL calc_ignore_weights: got %h expected all 16", weight_out); end
        tick();
        // Async reset at k = 8.
        err = 11'sd16;
        upd_start = 1'b1;
        tick();
        upd_start = 1'b0;
        repeat (8) tick();
        rstn = 1'b0;
        #1;
        n_checks++;
        if (weight_out !== '0 || upd_busy !== 1'b0 || upd_done !== 1'b0) begin
            n_errors++; $display("FAIL async_reset: w=%h busy=%b done=%b expected 0", weight_out, upd_busy, upd_done);
        end
        tick();
        rstn = 1'b1;
        tick();
        // w_load and upd_start together: start wins.
        w_init = rep_w(32'd5); w_load = 1'b1;
        run_update(11'sd16, rep_x(14'd256), de, bc);
        w_load = 1'b0;
        n_checks++;
        if (de !== 17 || weight_out !== rep_w(32'd16)) begin
            n_errors++; $display("FAIL start_beats_load: edge=%0d w=%h expected 17 all 16", de, weight_out);
        end
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (upd_done) dones++;
        end
        n_checks++;
        if (dones !== 0) begin n_errors++; $display("FAIL idle_no_done: got %0d expected 0", dones); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_rounding();
        test_abort();
        test_overflow();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
